// File: rtl/garage_pkg.sv
// garage_pkg: state, direction and command encodings shared by the garage controller and motor driver
// Contents: one-hot state codes, DIR_UP/DIR_DN, and the up/down command decode helpers.
package garage_pkg;
  typedef logic [4:0] state_t;
  localparam state_t ST_IDLE  = 5'b00001;
  localparam state_t ST_RAMP  = 5'b00010;
  localparam state_t ST_RUN   = 5'b00100;
  localparam state_t ST_BRAKE = 5'b01000;
  localparam state_t ST_FAULT = 5'b10000;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  function automatic logic cmd_is_up(input logic up, input logic dn);
    return up & ~dn;
  endfunction
  function automatic logic cmd_is_dn(input logic up, input logic dn);
    return dn & ~up;
  endfunction
  function automatic logic cmd_conflict(input logic up, input logic dn);
    return up & dn;
  endfunction
endpackage

// File: rtl/garage_pwm_gen.sv
// garage_pwm_gen: free-running PWM counter and duty comparator
// Ports: clk, rst (async, active-high); duty in; cnt = free-running counter; lt = (cnt < duty).
module garage_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic [PWM_W-1:0] cnt,
  output logic             lt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign lt = cnt < duty;
endmodule

// File: rtl/garage_motor_driver.sv
// garage_motor_driver: H-bridge sequencer with PWM soft-start, dead-time brake and latched conflict fault
// Ports: clk, rst (async, active-high); up_m/dn_m level commands; fault_clr acknowledge;
//        drv_up/drv_dn PWM-gated leg enables; busy (RAMP/RUN/BRAKE); fault (FAULT).
module garage_motor_driver import garage_pkg::*; #(
  parameter int PWM_W       = 8,
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic up_m,
  input  logic dn_m,
  input  logic fault_clr,
  output logic drv_up,
  output logic drv_dn,
  output logic busy,
  output logic fault
);
  localparam int DUTY_MAX = (1 << PWM_W) - 1;
  localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  state_t state, state_n;
  logic dir;
  logic [PWM_W-1:0] duty, pwm_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [DW-1:0] dead_cnt;
  logic pwm_lt, on;
  logic cmd_up, cmd_dn, conflict, want, ramp_tick, dead_done, sat;
  logic [PWM_W:0] duty_sum;
  garage_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk (clk),
    .rst (rst),
    .duty(duty),
    .cnt (pwm_cnt),
    .lt  (pwm_lt)
  );
  assign cmd_up    = cmd_is_up(up_m, dn_m);
  assign cmd_dn    = cmd_is_dn(up_m, dn_m);
  assign conflict  = cmd_conflict(up_m, dn_m);
  assign want      = dir == DIR_UP ? cmd_up : cmd_dn;
  assign ramp_tick = ramp_cnt == RW'(RAMP_DIV - 1);
  assign dead_done = dead_cnt == DW'(DEAD_CYCLES - 1);
  // one extra bit catches the add overflowing past full scale
  assign duty_sum  = {1'b0, duty} + (PWM_W+1)'(RAMP_STEP);
  assign sat       = duty_sum >= (PWM_W+1)'(DUTY_MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (conflict && state != ST_FAULT) state_n = ST_FAULT;
    else
      case (state)
        ST_IDLE:  state_n = (cmd_up | cmd_dn) ? ST_RAMP : ST_IDLE;
        ST_RAMP:  state_n = !want ? ST_BRAKE : (ramp_tick && sat) ? ST_RUN : ST_RAMP;
        ST_RUN:   state_n = want ? ST_RUN : ST_BRAKE;
        ST_BRAKE: state_n = dead_done ? ST_IDLE : ST_BRAKE;
        ST_FAULT: state_n = (fault_clr & ~up_m & ~dn_m) ? ST_IDLE : ST_FAULT;
        default:  state_n = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir      <= DIR_UP;
      duty     <= '0;
      ramp_cnt <= '0;
      dead_cnt <= '0;
    end else begin
      if (state_n == ST_FAULT) duty <= '0;
      else if (state == ST_IDLE && state_n == ST_RAMP) begin
        dir      <= cmd_dn ? DIR_DN : DIR_UP;
        duty     <= PWM_W'(RAMP_STEP);
        ramp_cnt <= '0;
      end else if (state == ST_RAMP && ramp_tick) begin
        ramp_cnt <= '0;
        duty     <= sat ? PWM_W'(DUTY_MAX) : duty_sum[PWM_W-1:0];
      end else if (state == ST_RAMP) ramp_cnt <= ramp_cnt + 1'b1;
      // held at zero outside BRAKE so every BRAKE entry starts from a cleared count
      dead_cnt <= (state == ST_BRAKE && !dead_done) ? dead_cnt + 1'b1 : '0;
    end
  always_comb begin
    on     = state == ST_RUN || (state == ST_RAMP && pwm_lt);
    drv_up = on && dir == DIR_UP;
    drv_dn = on && dir == DIR_DN;
    busy   = state == ST_RAMP || state == ST_RUN || state == ST_BRAKE;
    fault  = state == ST_FAULT;
  end
endmodule

// File: doc/garage_motor_driver.md
# garage_motor_driver

Power-stage sequencer directly downstream of the garage door controller. Consumes the controller's level motor commands (`up_m`, `dn_m`) and drives the two H-bridge leg enables. Adds a PWM soft-start ramp, a mandatory dead-time brake between any stop or reversal and the next run, and a latched fault on conflicting commands, so the controller never switches the motor directly.

## Interface
- `PWM_W`, default 8: width of the PWM counter and duty register; full-scale duty is `DUTY_MAX = 2^PWM_W - 1`.
- `RAMP_STEP`, default 16: duty increment per ramp tick; must satisfy 1 ≤ `RAMP_STEP` ≤ `DUTY_MAX`.
- `RAMP_DIV`, default 1000: clock cycles per ramp tick; must be ≥ 1.
- `DEAD_CYCLES`, default 50: cycles both legs are held off in BRAKE; must be ≥ 1.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `up_m`, input, 1: up command from the controller; a level, synchronous to `clk`.
- `dn_m`, input, 1: down command from the controller; a level, synchronous to `clk`.
- `fault_clr`, input, 1: fault acknowledge.
- `drv_up`, output, 1: up-leg enable, PWM-gated.
- `drv_dn`, output, 1: down-leg enable, PWM-gated.
- `busy`, output, 1: high in RAMP, RUN or BRAKE.
- `fault`, output, 1: high in FAULT.

## Operation
- Registers:
  - `state` (one-hot; IDLE, RAMP, RUN, BRAKE, FAULT).
  - `dir` (UP/DN), `duty[PWM_W-1:0]`, `pwm_cnt[PWM_W-1:0]`.
  - `ramp_cnt`, sized to hold `RAMP_DIV-1`.
  - `dead_cnt`, sized to hold `DEAD_CYCLES-1`.
- Command decode: `cmd_up = up_m & ~dn_m`, `cmd_dn = dn_m & ~up_m`, `conflict = up_m & dn_m`.
- FAULT has top priority. `conflict` in any state other than FAULT moves to FAULT on the next edge; this overrides every transition below.
- IDLE:
  - On `cmd_up` or `cmd_dn`: latch `dir`, set `duty = RAMP_STEP`, clear `ramp_cnt`, go to RAMP.
  - Otherwise stay in IDLE.
- RAMP:
  - `ramp_cnt` counts 0 to `RAMP_DIV-1`, then wraps.
  - On each wrap (ramp tick), `duty` increases by `RAMP_STEP`.
  - If the sum reaches or exceeds `DUTY_MAX`, or the add overflows, saturate `duty` at `DUTY_MAX` and go to RUN on that same edge.
  - If the command for the latched `dir` is lost (command dropped or reversed), go to BRAKE.
- RUN:
  - `duty` holds at `DUTY_MAX`.
  - If the command for the latched `dir` is lost, go to BRAKE.
- BRAKE:
  - Clear `dead_cnt` on entry; both legs off.
  - Leave to IDLE when `dead_cnt = DEAD_CYCLES-1`. Commands are ignored here except `conflict`.
  - After IDLE, a still-present command re-enters RAMP with the newly latched `dir`.
- FAULT:
  - Both legs off, `fault = 1`, `duty = 0`.
  - Leave to IDLE only on an edge where `fault_clr = 1` and `up_m = dn_m = 0`. Otherwise stay.
- PWM:
  - `pwm_cnt` free-runs from reset and wraps at `DUTY_MAX` to 0.
  - `on = (state == RUN) | (state == RAMP & pwm_cnt < duty)`.
- Outputs:
  - `drv_up = on & dir == UP`; `drv_dn = on & dir == DN`.
  - Both are decoded only from registers; there is no combinational path from any input.
  - `drv_up & drv_dn` must never be 1.
- Reset values: `state = IDLE`, `dir = UP`, `duty = 0`, all counters 0. All outputs 0.

## Timing
- A command change sampled at edge k changes `state` at edge k. Outputs follow after edge k, so latency is 1 cycle from the input being valid.
- Ramp length: from RAMP entry, RUN is reached after `ceil((DUTY_MAX - RAMP_STEP) / RAMP_STEP)` ticks × `RAMP_DIV` cycles.
- Stop or reversal to re-drive: both legs are off for exactly `DEAD_CYCLES` cycles in BRAKE, plus 1 cycle in IDLE, before RAMP.
- Fault entry: legs off in the cycle after `conflict` is sampled.
- Reset mid-operation: outputs go to 0 immediately (asynchronously), with no dead-time guarantee required.

## Structure
- `garage_pkg`:
  - state localparams (one-hot, 5 bits);
  - `DIR_UP`/`DIR_DN` constants;
  - shared with the controller for the command encoding.
- One sub-module, `garage_pwm_gen`: the free-running `pwm_cnt` plus the `pwm_cnt < duty` comparator, parameterised by `PWM_W`.
- The FSM, ramp prescaler and dead-time counter stay in the top module.

## Test plan
All scenarios use `PWM_W=4`, `RAMP_STEP=4`, `RAMP_DIV=2`, `DEAD_CYCLES=3`.
- Reset: assert `rst` mid-cycle → all outputs 0 at once; after release, `pwm_cnt` counts 0..15 and wraps.
- Up ramp: `up_m=1` held → `duty` goes 4, 8, 12, then 15, one step every 2 cycles → RUN. `drv_up` duty matches `pwm_cnt < duty`; `drv_up` stays constantly 1 in RUN; `drv_dn` stays 0.
- Reversal mid-ramp: at `duty=8` switch to `dn_m=1` → both legs 0 for exactly 4 cycles (3 BRAKE + 1 IDLE), then `drv_dn` ramps from `duty=4`.
- Stop from RUN: drop `up_m` → BRAKE for 3 cycles → IDLE; `busy` falls with IDLE entry.
- Conflict: `up_m=dn_m=1` during RUN → next cycle `fault=1`, legs 0. `fault_clr=1` with commands still high → stays in FAULT. `fault_clr=1` with commands low → IDLE.
- Reset during RAMP: `rst` pulse → IDLE and `duty=0`; with `up_m` still high after release, the ramp restarts at `duty=4`.
